// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : 32 x 64-bit general-purpose register file. Two combinational
//            read ports, one clocked write port with byte-lane selective
//            writes (PPP field) and write-through forwarding to both ports.
//            Vectors are big-endian: bit 0 is the MSB, byte 0 is bits [0:7].
// Revision : 1.0  initial release
// ============================================================================
module register_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [2:0]              sel,
  input  logic [0:DATA_WIDTH-1]   data_in,
  input  logic [ADDR_WIDTH-1:0]   addr_wr,
  input  logic [ADDR_WIDTH-1:0]   addr_rd_0,
  input  logic [ADDR_WIDTH-1:0]   addr_rd_1,
  output logic [0:DATA_WIDTH-1]   data_out_0,
  output logic [0:DATA_WIDTH-1]   data_out_1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // PPP lane-select encodings; 101/110/111 are reserved and select no lanes
  localparam logic [2:0] C_SEL_ALL   = 3'b000;
  localparam logic [2:0] C_SEL_UPPER = 3'b001;
  localparam logic [2:0] C_SEL_LOWER = 3'b010;
  localparam logic [2:0] C_SEL_EVEN  = 3'b011;
  localparam logic [2:0] C_SEL_ODD   = 3'b100;

  logic [0:DATA_WIDTH-1] mem_q [0:DEPTH-1];
  logic [0:DATA_WIDTH-1] mem_d [0:DEPTH-1];

  logic [0:DATA_WIDTH-1] w_lane_mask;
  logic [0:DATA_WIDTH-1] w_merged;

  // Per-bit lane mask: each bit knows statically which half and which byte
  // parity it belongs to, so the decode reduces to a compare on sel.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    localparam bit C_UPPER = (i < DATA_WIDTH / 2);
    localparam bit C_EVEN  = (((i / 8) % 2) == 0);
    assign w_lane_mask[i] = (sel == C_SEL_ALL)
                          | ((sel == C_SEL_UPPER) &&  C_UPPER)
                          | ((sel == C_SEL_LOWER) && !C_UPPER)
                          | ((sel == C_SEL_EVEN)  &&  C_EVEN)
                          | ((sel == C_SEL_ODD)   && !C_EVEN);
  end

  // Value the write target will hold after the edge: new data in selected
  // lanes, current contents elsewhere. Also the forwarded read value.
  always_comb begin
    w_merged = (data_in & w_lane_mask) | (mem_q[addr_wr] & ~w_lane_mask);
  end

  // Next-state of the array: reset clears everything and wins over a write
  always_comb begin
    mem_d = mem_q;
    if (reset) begin
      mem_d = '{default: '0};
    end else if (we) begin
      mem_d[addr_wr] = w_merged;
    end
  end

  // Register array update
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read ports with independent write-through forwarding. A reserved sel
  // yields an all-zero mask, so the forwarded value equals the stored one.
  // Forwarding is not gated by reset: outputs reflect stored contents plus
  // any pending write even while reset is asserted.
  always_comb begin
    data_out_0 = (we && (addr_rd_0 == addr_wr)) ? w_merged : mem_q[addr_rd_0];
    data_out_1 = (we && (addr_rd_1 == addr_wr)) ? w_merged : mem_q[addr_rd_1];
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Directed self-checking bench for register_file.
// Revision : 1.0  initial release
// ============================================================================
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  sel;
  logic [0:63] data_in;
  logic [4:0]  addr_wr;
  logic [4:0]  addr_rd_0;
  logic [4:0]  addr_rd_1;
  logic [0:63] data_out_0;
  logic [0:63] data_out_1;

  int n_tests = 0;
  int n_fail  = 0;

  register_file #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .sel        (sel),
    .data_in    (data_in),
    .addr_wr    (addr_wr),
    .addr_rd_0  (addr_rd_0),
    .addr_rd_1  (addr_rd_1),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [0:63] got, input logic [0:63] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:63] pattern_for_sel(input int s);
    case (s)
      0:       return 64'h1111111111111111;
      1:       return 64'h11111111FFFFFFFF;
      2:       return 64'hFFFFFFFF11111111;
      3:       return 64'h11FF11FF11FF11FF;
      4:       return 64'hFF11FF11FF11FF11;
      default: return 64'hFFFFFFFFFFFFFFFF;
    endcase
  endfunction

  initial begin
    reset = 1'b1; we = 1'b0; sel = 3'b000; data_in = '0;
    addr_wr = '0; addr_rd_0 = '0; addr_rd_1 = '0;
    #2;

    // Reset for one cycle, then every entry reads zero
    tick();
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      addr_rd_0 = 5'(a);
      #1;
      check($sformatf("reset_rd0[%0d]", a), data_out_0, 64'h0);
    end

    // Full writes of all-F with forwarding visible on both ports
    we = 1'b1; sel = 3'b000; data_in = 64'hFFFFFFFFFFFFFFFF;
    for (int a = 0; a < 32; a++) begin
      addr_wr = 5'(a); addr_rd_0 = 5'(a); addr_rd_1 = 5'(a);
      #1;
      check($sformatf("fwd_full_p0[%0d]", a), data_out_0, 64'hFFFFFFFFFFFFFFFF);
      check($sformatf("fwd_full_p1[%0d]", a), data_out_1, 64'hFFFFFFFFFFFFFFFF);
      tick();
    end
    we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      addr_rd_0 = 5'(a); addr_rd_1 = 5'(31 - a);
      #1;
      check($sformatf("full_p0[%0d]", a), data_out_0, 64'hFFFFFFFFFFFFFFFF);
      check($sformatf("full_p1[%0d]", 31 - a), data_out_1, 64'hFFFFFFFFFFFFFFFF);
    end

    // Lane-selective writes: address k uses sel = k mod 8
    we = 1'b1; data_in = 64'h1111111111111111;
    for (int k = 0; k < 32; k++) begin
      addr_wr = 5'(k); sel = 3'(k % 8);
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 32; k++) begin
      addr_rd_0 = 5'(k);
      #1;
      check($sformatf("lanes[%0d]", k), data_out_0, pattern_for_sel(k % 8));
    end

    // Partial-write forwarding: restore entry 3 to all-F, then write upper half
    we = 1'b1; sel = 3'b000; addr_wr = 5'd3; data_in = 64'hFFFFFFFFFFFFFFFF;
    tick();
    sel = 3'b001; data_in = 64'h1234567800000000; addr_rd_0 = 5'd3;
    #1;
    check("fwd_partial", data_out_0, 64'h12345678FFFFFFFF);
    tick();
    we = 1'b0;
    #1;
    check("partial_stored", data_out_0, 64'h12345678FFFFFFFF);

    // Dual-port independence: port 0 forwards entry 5, port 1 reads entry 9
    we = 1'b1; sel = 3'b000; addr_wr = 5'd5; data_in = 64'hA5A5A5A5A5A5A5A5;
    addr_rd_0 = 5'd5; addr_rd_1 = 5'd9;
    #1;
    check("dual_p0_fwd", data_out_0, 64'hA5A5A5A5A5A5A5A5);
    check("dual_p1_stored", data_out_1, 64'h11111111FFFFFFFF);
    tick();
    we = 1'b0;
    #1;
    check("dual_p0_stored", data_out_0, 64'hA5A5A5A5A5A5A5A5);

    // Reserved sel: no forwarding effect and no update
    we = 1'b1; sel = 3'b110; addr_wr = 5'd5; data_in = 64'h0;
    #1;
    check("reserved_fwd", data_out_0, 64'hA5A5A5A5A5A5A5A5);
    tick();
    we = 1'b0;
    #1;
    check("reserved_stored", data_out_0, 64'hA5A5A5A5A5A5A5A5);

    // Odd-byte write forwarded on port 1 over a known stored value
    we = 1'b1; sel = 3'b100; addr_wr = 5'd5; data_in = 64'h0000000000000000;
    addr_rd_1 = 5'd5;
    #1;
    check("odd_fwd_p1", data_out_1, 64'hA500A500A500A500);
    tick();
    we = 1'b0;

    // Reset during a write: forwarding still visible, reset wins at the edge
    reset = 1'b1; we = 1'b1; sel = 3'b000; addr_wr = 5'd7;
    data_in = 64'hDEADBEEFCAFEF00D; addr_rd_0 = 5'd7; addr_rd_1 = 5'd9;
    #1;
    check("reset_fwd_p0", data_out_0, 64'hDEADBEEFCAFEF00D);
    check("reset_stored_p1", data_out_1, 64'h11111111FFFFFFFF);
    tick();
    reset = 1'b0; we = 1'b0;
    #1;
    check("reset_wins_7", data_out_0, 64'h0);
    check("reset_clear_9", data_out_1, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
